// File: rtl/ldm_stm_sequencer.sv
`timescale 1ns/1ps
// Block-transfer sequencer: moves a register list to/from memory (LDM/STM) with optional base writeback.
// Latency: 1 setup cycle, then one cycle per register when memDone is held high, then optional WB, then DONE.
// Backpressure: memDone=0 stalls the current transfer indefinitely with address and register index held.
module ldm_stm_sequencer #(
  parameter int STEP = 4  // byte address increment per transferred register
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        start,
  input  logic        L,
  input  logic        U,
  input  logic        P,
  input  logic        W,
  input  logic [3:0]  Rn,
  input  logic [15:0] regList,
  input  logic [31:0] baseAddr,
  input  logic        memDone,
  input  logic [31:0] memDataIn,
  output logic [3:0]  regAddr,
  output logic        RW,
  output logic [31:0] regWData,
  output logic        memEnable,
  output logic        memRW,
  output logic [31:0] memAddr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT       state;
  logic        latL;
  logic        latU;
  logic        latP;
  logic        latW;
  logic [3:0]  latRn;
  logic        rnInList;    // base register is part of the list (suppresses load writeback)
  logic [15:0] pending;     // registers still to transfer
  logic [31:0] curAddr;     // holds base until SETUP, then the current transfer address
  logic [31:0] finalAddr;   // writeback value

  logic [3:0]  lowIdx;
  logic [4:0]  popCnt;
  logic [15:0] pendingNext;
  logic [31:0] stepW;
  logic [31:0] span;

  assign stepW = 32'(STEP);
  assign span  = stepW * 32'(popCnt);

  // Lowest pending register index: transfers always go in ascending register order.
  always_comb begin
    lowIdx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) lowIdx = 4'(i);
    end
  end

  // Number of registers in the latched list.
  always_comb begin
    popCnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      popCnt = popCnt + 5'(pending[i]);
    end
  end

  // Pending set after the current transfer completes.
  assign pendingNext = pending & ~(16'd1 << lowIdx);

  // Sequencer state and datapath registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      latL      <= 1'b0;
      latU      <= 1'b0;
      latP      <= 1'b0;
      latW      <= 1'b0;
      latRn     <= 4'd0;
      rnInList  <= 1'b0;
      pending   <= 16'd0;
      curAddr   <= 32'd0;
      finalAddr <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            latL     <= L;
            latU     <= U;
            latP     <= P;
            latW     <= W;
            latRn    <= Rn;
            rnInList <= regList[Rn];
            pending  <= regList;
            curAddr  <= baseAddr;
            state    <= SETUP;
          end
        end
        SETUP: begin
          // Lowest address of the block; descending blocks still walk upward from here.
          case ({latU, latP})
            2'b10:   curAddr <= curAddr;
            2'b11:   curAddr <= curAddr + stepW;
            2'b00:   curAddr <= curAddr - span + stepW;
            default: curAddr <= curAddr - span;
          endcase
          finalAddr <= latU ? (curAddr + span) : (curAddr - span);
          state     <= (popCnt == 5'd0) ? DONE : XFER;
        end
        XFER: begin
          if (memDone) begin
            pending <= pendingNext;
            curAddr <= curAddr + stepW;
            if (pendingNext == 16'd0) begin
              // A load that overwrites the base register takes precedence over writeback.
              state <= (latW && !(latL && rnInList)) ? WB : DONE;
            end
          end
        end
        WB:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state; load data passes straight through in the memDone cycle.
  always_comb begin
    RW        = 1'b1;
    memEnable = 1'b0;
    memRW     = 1'b1;
    regAddr   = 4'd0;
    regWData  = 32'd0;
    memAddr   = 32'd0;
    done      = 1'b0;
    case (state)
      XFER: begin
        memEnable = 1'b1;
        memRW     = latL;
        memAddr   = {curAddr[31:2], 2'b00};
        regAddr   = lowIdx;
        if (latL && memDone) begin
          RW       = 1'b0;
          regWData = memDataIn;
        end
      end
      WB: begin
        RW       = 1'b0;
        regAddr  = latRn;
        regWData = finalAddr;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for ldm_stm_sequencer: table of block transfers checked through an event
// scoreboard, plus a hand-written wrap-around / mid-sequence reset sequence.
module tb_ldm_stm_sequencer;

  localparam logic [31:0] DKEY = 32'h5A5A_0000;  // load data = address ^ DKEY
  localparam int KXFER = 0;
  localparam int KWB   = 1;
  localparam int KDONE = 2;

  logic        CLK;
  logic        CLR;
  logic        start;
  logic        L, U, P, W;
  logic [3:0]  Rn;
  logic [15:0] regList;
  logic [31:0] baseAddr;
  logic        memDone;
  logic [31:0] memDataIn;
  logic [3:0]  regAddr;
  logic        RW;
  logic [31:0] regWData;
  logic        memEnable;
  logic        memRW;
  logic [31:0] memAddr;
  logic        busy;
  logic        done;

  ldm_stm_sequencer #(.STEP(4)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .L(L), .U(U), .P(P), .W(W),
    .Rn(Rn), .regList(regList), .baseAddr(baseAddr),
    .memDone(memDone), .memDataIn(memDataIn),
    .regAddr(regAddr), .RW(RW), .regWData(regWData),
    .memEnable(memEnable), .memRW(memRW), .memAddr(memAddr),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign memDataIn = memAddr ^ DKEY;

  typedef struct {
    logic        L, U, P, W;
    logic [3:0]  Rn;
    logic [15:0] list;
    logic [31:0] base;
    int          waits;
    logic [31:0] firstAddr;
    logic [31:0] finalAddr;
    logic        expWb;
  } vecT;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  rg;
    logic        mrw;
    logic        rw;
    logic [31:0] data;
    logic        chkData;
  } evT;

  vecT vecs[8];
  evT  sb[$];
  evT  monEv;
  int  checks   = 0;
  int  passes   = 0;
  int  doneCnt  = 0;
  bit  monEn    = 1'b0;
  int  curWaits = 0;
  int  waitCnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic unexpected(input string what);
    checks++;
    $display("FAIL unexpected %s: memAddr 0x%08h regAddr %0d RW %0b, expected no event", what, memAddr, regAddr, RW);
  endtask

  // Memory model: answers after curWaits wait cycles per transfer.
  initial begin
    memDone = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (memEnable && waitCnt < curWaits) begin
        memDone = 1'b0;
        waitCnt++;
      end else if (memEnable) begin
        memDone = 1'b1;
        waitCnt = 0;
      end else begin
        memDone = 1'b0;
        waitCnt = 0;
      end
    end
  end

  // Output monitor: classifies each cycle and compares against the scoreboard head.
  always @(negedge CLK) begin
    if (monEn && CLR) begin
      if (memEnable && memDone) begin
        if (sb.size() == 0) unexpected("transfer");
        else begin
          monEv = sb.pop_front();
          chk("xfer kind", KXFER, monEv.kind);
          chk("xfer memAddr", memAddr, monEv.addr);
          chk("xfer regAddr", 32'(regAddr), 32'(monEv.rg));
          chk("xfer memRW", 32'(memRW), 32'(monEv.mrw));
          chk("xfer RW", 32'(RW), 32'(monEv.rw));
          if (monEv.chkData) chk("xfer regWData", regWData, monEv.data);
        end
      end else if (memEnable) begin
        if (sb.size() == 0) unexpected("wait state");
        else begin
          chk("wait memAddr held", memAddr, sb[0].addr);
          chk("wait regAddr held", 32'(regAddr), 32'(sb[0].rg));
          chk("wait RW read", 32'(RW), 32'd1);
        end
      end else if (!RW) begin
        if (sb.size() == 0) unexpected("register write");
        else begin
          monEv = sb.pop_front();
          chk("wb kind", KWB, monEv.kind);
          chk("wb regAddr", 32'(regAddr), 32'(monEv.rg));
          chk("wb regWData", regWData, monEv.data);
        end
      end
      if (done) begin
        doneCnt++;
        if (sb.size() == 0) unexpected("done");
        else begin
          monEv = sb.pop_front();
          chk("done kind", KDONE, monEv.kind);
          chk("busy during done", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic pushModel(input vecT v);
    evT e;
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (v.list[i]) begin
        e.kind    = KXFER;
        e.addr    = v.firstAddr + 32'(4 * k);
        e.rg      = 4'(i);
        e.mrw     = v.L;
        e.rw      = !v.L;
        e.data    = e.addr ^ DKEY;
        e.chkData = v.L;
        sb.push_back(e);
        k++;
      end
    end
    if (v.expWb) begin
      e.kind = KWB; e.addr = 32'd0; e.rg = v.Rn; e.mrw = 1'b1; e.rw = 1'b0;
      e.data = v.finalAddr; e.chkData = 1'b1;
      sb.push_back(e);
    end
    e.kind = KDONE; e.addr = 32'd0; e.rg = 4'd0; e.mrw = 1'b1; e.rw = 1'b1;
    e.data = 32'd0; e.chkData = 1'b0;
    sb.push_back(e);
  endtask

  task automatic runCase(input vecT v);
    int target;
    pushModel(v);
    curWaits = v.waits;
    target   = doneCnt + 1;
    @(posedge CLK); #1;
    L = v.L; U = v.U; P = v.P; W = v.W; Rn = v.Rn; regList = v.list; baseAddr = v.base;
    start = 1'b1;
    @(posedge CLK); #1;
    // Scramble the request fields: the sequence must run from the latched copy.
    start = 1'b0;
    L = ~v.L; U = ~v.U; P = ~v.P; W = ~v.W; Rn = ~v.Rn; regList = ~v.list; baseAddr = $urandom();
    @(negedge CLK);
    chk("busy after start", 32'(busy), 32'd1);
    // A start pulse while the sequence is running must be ignored.
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    for (int c = 0; c < 400 && doneCnt < target; c++) @(posedge CLK);
    if (doneCnt < target) begin
      checks++;
      $display("FAIL done timeout: done count %0d, expected %0d", doneCnt, target);
    end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge CLK);
    chk("busy back in idle", 32'(busy), 32'd0);
    chk("memEnable in idle", 32'(memEnable), 32'd0);
  endtask

  task automatic chkDefaults(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " memEnable"}, 32'(memEnable), 32'd0);
    chk({tag, " RW"}, 32'(RW), 32'd1);
    chk({tag, " memRW"}, 32'(memRW), 32'd1);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " memAddr"}, memAddr, 32'd0);
    chk({tag, " regAddr"}, 32'(regAddr), 32'd0);
    chk({tag, " regWData"}, regWData, 32'd0);
  endtask

  initial begin
    //            L     U     P     W     Rn     list        base           waits first          final          wb
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 16'h000B, 32'h0000_0100, 0, 32'h0000_0100, 32'h0000_010C, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'hC000, 32'h0000_0200, 0, 32'h0000_01F8, 32'h0000_01F8, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2,  16'h0090, 32'h0000_1000, 2, 32'h0000_1004, 32'h0000_1008, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  16'h0000, 32'h0000_0300, 0, 32'h0000_0300, 32'h0000_0300, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  16'h0006, 32'h0000_0040, 0, 32'h0000_0040, 32'h0000_0048, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  16'h8001, 32'h0000_0500, 1, 32'h0000_0504, 32'h0000_0508, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0111, 32'h0000_0800, 1, 32'h0000_07F8, 32'h0000_07F4, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'hFFFF, 32'h0000_0000, 0, 32'hFFFF_FFC0, 32'hFFFF_FFC0, 1'b1};

    CLR = 1'b0; start = 1'b0; L = 1'b0; U = 1'b0; P = 1'b0; W = 1'b0;
    Rn = 4'd0; regList = 16'd0; baseAddr = 32'd0;
    #12;
    chkDefaults("reset");
    @(posedge CLK); #1 CLR = 1'b1;
    monEn = 1'b1;

    for (int i = 0; i < 8; i++) runCase(vecs[i]);

    // Wrap-around then reset in the middle of the second transfer.
    monEn = 1'b0;
    curWaits = 0;
    @(posedge CLK); #1;
    L = 1'b1; U = 1'b1; P = 1'b0; W = 1'b1; Rn = 4'd13; regList = 16'h0003; baseAddr = 32'hFFFF_FFFC;
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("wrap first memAddr", memAddr, 32'hFFFF_FFFC);
    chk("wrap first regAddr", 32'(regAddr), 32'd0);
    chk("wrap first RW", 32'(RW), 32'd0);
    chk("wrap first regWData", regWData, 32'hFFFF_FFFC ^ DKEY);
    @(negedge CLK);
    chk("wrap second memAddr", memAddr, 32'h0000_0000);
    chk("wrap second regAddr", 32'(regAddr), 32'd1);
    chk("wrap second memEnable", 32'(memEnable), 32'd1);
    #1 CLR = 1'b0;
    #1;
    chkDefaults("async clear");
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("held reset RW", 32'(RW), 32'd1);
      chk("held reset memEnable", 32'(memEnable), 32'd0);
    end
    @(posedge CLK); #1 CLR = 1'b1;
    @(negedge CLK);
    chkDefaults("after release");
    monEn = 1'b1;
    runCase(vecs[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 The block SHALL have one parameter: STEP, 4, byte address increment per transferred register.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 CLR  input  1  asynchronous active-low reset (0 = clear).
REQ-004 start  input  1  one-cycle request, sampled only in IDLE.
REQ-005 L  input  1  1 = load (memory -> registers), 0 = store (registers -> memory).
REQ-006 U  input  1  1 = ascending block, 0 = descending block.
REQ-007 P  input  1  1 = pre-index, 0 = post-index.
REQ-008 W  input  1  1 = base writeback requested.
REQ-009 Rn  input  4  base register index.
REQ-010 regList  input  16  register list; bit i selects Ri.
REQ-011 baseAddr  input  32  base register value at start.
REQ-012 memDone  input  1  memory completion; sampled only while memEnable=1.
REQ-013 memDataIn  input  32  load data from memory, valid when memDone=1.
REQ-014 regAddr  output  4  register file address (read for store, write for load/writeback).
REQ-015 RW  output  1  register file control, 1 = read, 0 = write.
REQ-016 regWData  output  32  data to register file.
REQ-017 memEnable  output  1  memory request.
REQ-018 memRW  output  1  1 = memory read, 0 = memory write.
REQ-019 memAddr  output  32  word address; bits [1:0] always 0.
REQ-020 busy  output  1  high from the cycle after start acceptance through DONE.
REQ-021 done  output  1  one-cycle completion pulse.

Function
REQ-022 States SHALL be IDLE, SETUP, XFER, WB, DONE, held in registers updated on CLK.
REQ-023 IDLE: start=1 latches L, U, P, W, Rn, regList and baseAddr, then moves to SETUP; start outside IDLE SHALL be ignored.
REQ-024 SETUP (1 cycle): n = popcount(regList); first address = base (U=1,P=0), base+4 (U=1,P=1), base-4n+4 (U=0,P=0), base-4n (U=0,P=1); final = U ? base+4n : base-4n; goes to XFER if n>0, otherwise to DONE.
REQ-025 Registers SHALL transfer in ascending index order at ascending addresses, regardless of U.
REQ-026 XFER: memEnable=1, memRW=L, memAddr=current address, regAddr=lowest pending index.
REQ-027 XFER store: RW=1 (register read); the transfer completes on the cycle memDone=1.
REQ-028 XFER load: RW=0 and regWData=memDataIn combinationally during the memDone=1 cycle only; otherwise RW=1.
REQ-029 While memDone=0, memAddr and regAddr SHALL stay stable and memEnable SHALL remain high (wait states unlimited).
REQ-030 On completion, the transfer clears its pending bit and advances the address by STEP. A cycle with memDone held high completes one transfer per cycle.
REQ-031 After the last transfer: go to WB if W=1 and not (L=1 and bit Rn set in regList); otherwise go to DONE.
REQ-032 WB (1 cycle): RW=0, regAddr=Rn, regWData=final address, memEnable=0.
REQ-033 DONE (1 cycle): done=1, then return to IDLE.
REQ-034 All address arithmetic SHALL be modulo 2^32 (wrap-around).
REQ-035 Output defaults outside the states above: RW=1, memEnable=0, memRW=1, regAddr=0, regWData=0, memAddr=0, done=0.

Reset
REQ-036 CLR=0 SHALL immediately force IDLE and the REQ-035 defaults with busy=0, independent of CLK.
REQ-037 Reset mid-operation SHALL abandon the sequence: no further register writes and no writeback.
REQ-038 After CLR returns to 1, the first start SHALL be accepted normally.

Verification
REQ-039 LDM IA: base=0x100, list=0x000B, L=1 U=1 P=0 W=1 Rn=13, memDone=1 -> memAddr 0x100/0x104/0x108 writes R0/R1/R3 on consecutive cycles; WB writes R13=0x10C; done follows.
REQ-040 STM DB: base=0x200, list=0xC000, L=0 U=0 P=1 W=1 Rn=13 -> R14 read at 0x1F8, R15 read at 0x1FC, memRW=0; WB writes R13=0x1F8.
REQ-041 Wait states: memDone low 2 cycles per transfer -> memEnable, memAddr and regAddr held; RW=0 only in the memDone cycle (load).
REQ-042 Empty list: regList=0 -> SETUP then DONE; memEnable and RW=0 never asserted.
REQ-043 LDM with Rn=1 in list=0x0006, W=1 -> R1 and R2 loaded; no WB cycle.
REQ-044 Wrap and reset: base=0xFFFFFFFC, IA, 2 registers -> memAddr 0xFFFFFFFC, then 0x00000000. CLR=0 during the second XFER -> outputs go to defaults at once, and there are no further writes.
